// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: base opcodes, immediate formats and the
// per-opcode class table used by the decode stage.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef struct packed {
    logic     writes_rd;
    logic     uses_rs1;
    logic     uses_rs2;
    logic     illegal;
    imm_fmt_e imm_fmt;
  } op_class_t;

  function automatic op_class_t op_class(input logic [6:0] opcode);
    op_class_t c;
    c = '{writes_rd: 1'b0, uses_rs1: 1'b0, uses_rs2: 1'b0, illegal: 1'b0, imm_fmt: IMM_NONE};
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin c.writes_rd = 1'b1; c.imm_fmt = IMM_U; end
      OPC_JAL:            begin c.writes_rd = 1'b1; c.imm_fmt = IMM_J; end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        c.writes_rd = 1'b1; c.uses_rs1 = 1'b1; c.imm_fmt = IMM_I;
      end
      OPC_BRANCH: begin c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1; c.imm_fmt = IMM_B; end
      OPC_STORE:  begin c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1; c.imm_fmt = IMM_S; end
      OPC_OP:     begin c.writes_rd = 1'b1; c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1; end
      default:    c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Per-register pending-write scoreboard with the hazard query for one instruction.
// With ID_STAGE_WB_BYPASS_EN a bit being cleared this cycle no longer blocks.
module id_scoreboard (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       set_en,
  input  logic [4:0] set_addr,
  input  logic       clr_en,
  input  logic [4:0] clr_addr,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rd,
  input  logic       use_rs1,
  input  logic       use_rs2,
  input  logic       use_rd,
  output logic       hazard
);

  logic [31:0] pending;
  logic [31:0] pending_nxt;
  logic [31:0] pending_eff;

  // Set is applied after clear so an issue and a writeback to the same register leave it pending.
  always_comb begin
    pending_nxt = pending;
    if (clr_en && clr_addr != 5'd0) pending_nxt[clr_addr] = 1'b0;
    if (set_en && set_addr != 5'd0) pending_nxt[set_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
    if (flush) pending_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  always_comb begin
    pending_eff = pending;
`ifdef ID_STAGE_WB_BYPASS_EN
    if (clr_en && clr_addr != 5'd0) pending_eff[clr_addr] = 1'b0;
`endif
  end

  assign hazard = (use_rs1 && pending_eff[rs1]) ||
                  (use_rs2 && pending_eff[rs2]) ||
                  (use_rd  && pending_eff[rd]);

endmodule

// File: rtl/id_stage.sv
// Decode/register-read stage of the RV32I pipeline: decodes fetch output, reads the
// register file and registers operands for execute. Optional bypass: ID_STAGE_WB_BYPASS_EN.
module id_stage
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rf_a1,
  output logic [4:0]      rf_a2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic            ex_illegal,
  input  logic            ex_flush
);

  op_class_t       cls;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] imm, op1, op2;
  logic            sb_hazard, hazard, issue;

  assign rs1   = if_instr[19:15];
  assign rs2   = if_instr[24:20];
  assign rd    = if_instr[11:7];
  assign cls   = op_class(if_instr[6:0]);
  assign imm   = gen_imm(if_instr, cls.imm_fmt);
  assign rf_a1 = rs1;
  assign rf_a2 = rs2;

  // valid/ready: a transfer happens on a rising edge with valid && ready; the offering
  // side holds valid and its payload unchanged until that edge.
  assign hazard   = if_valid && sb_hazard;
  assign if_ready = (!ex_valid || ex_ready) && !hazard && !ex_flush;
  assign issue    = if_valid && if_ready;

  // x0 reads as zero whatever the (unreset) register file returns.
  always_comb begin
    op1 = rf_rd1;
    op2 = rf_rd2;
`ifdef ID_STAGE_WB_BYPASS_EN
    if (wb_we && wb_addr == rs1) op1 = wb_data;
    if (wb_we && wb_addr == rs2) op2 = wb_data;
`endif
    if (rs1 == 5'd0) op1 = '0;
    if (rs2 == 5'd0) op2 = '0;
  end

`ifndef ID_STAGE_WB_BYPASS_EN
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
`endif

  id_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .flush    (ex_flush),
    .set_en   (issue && cls.writes_rd),
    .set_addr (rd),
    .clr_en   (wb_we),
    .clr_addr (wb_addr),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .use_rs1  (cls.uses_rs1),
    .use_rs2  (cls.uses_rs2),
    .use_rd   (cls.writes_rd),
    .hazard   (sb_hazard)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rs1_val <= '0;
      ex_rs2_val <= '0;
      ex_imm     <= '0;
      ex_rd      <= '0;
      ex_opcode  <= '0;
      ex_funct3  <= '0;
      ex_funct7  <= '0;
      ex_illegal <= 1'b0;
    end else if (ex_flush) begin
      ex_valid <= 1'b0;
    end else if (issue) begin
      ex_valid   <= 1'b1;
      ex_pc      <= if_pc;
      ex_rs1_val <= op1;
      ex_rs2_val <= op2;
      ex_imm     <= imm;
      ex_rd      <= cls.writes_rd ? rd : 5'd0;
      ex_opcode  <= if_instr[6:0];
      ex_funct3  <= if_instr[14:12];
      ex_funct7  <= if_instr[31:25];
      ex_illegal <= cls.illegal;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected execute-side records are queued when an
// instruction is offered and compared when execute consumes the output register.
module tb_id_stage;
  localparam int W = 151;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  rf_a1, rf_a2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rd;
  logic [6:0]  ex_opcode, ex_funct7;
  logic [2:0]  ex_funct3;
  logic        ex_illegal, ex_flush;

  logic [31:0]  rf_mem [32];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_vec;
  int checks = 0;
  int failures = 0;

  id_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_funct7(ex_funct7), .ex_illegal(ex_illegal), .ex_flush(ex_flush)
  );

  // clock / register file model
  always #5 clk = ~clk;

  assign rf_rd1  = rf_mem[rf_a1];
  assign rf_rd2  = rf_mem[rf_a2];
  assign obs_vec = {ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_opcode, ex_funct3,
                    ex_funct7, ex_illegal};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h1000_0000 + 32'h0101 * i;
      rf_mem[0] <= 32'hDEAD_BEEF;
    end else if (wb_we) begin
      rf_mem[wb_addr] <= wb_data;
    end
  end

  // encoders
  function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] rsv(input logic [4:0] src);
    return (src == 5'd0) ? 32'h0 : rf_mem[src];
  endfunction

  function automatic logic [W-1:0] mk_exp(input logic [31:0] instr, input logic [31:0] pc,
                                          input logic [31:0] r1, input logic [31:0] r2,
                                          input logic [31:0] imm, input logic [4:0] rd,
                                          input logic ill);
    return {pc, r1, r2, imm, rd, instr[6:0], instr[14:12], instr[31:25], ill};
  endfunction

  // scoreboard / checking
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    logic [W-1:0] e;
    #1;
    if (ex_valid === 1'b1 && ex_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL spurious_out obs=%0h exp=none", obs_vec);
      end else begin
        e = exp_q.pop_front();
        chk("ex_out", obs_vec, e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // drivers
  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
  endtask

  task automatic issue(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                       input logic [4:0] rd, input logic ill);
    drive(instr, pc);
    #1;
    chk(tag, {150'b0, if_ready}, 151'd1);
    exp_q.push_back(mk_exp(instr, pc, r1, r2, imm, rd, ill));
    tick();
    if_valid = 1'b0;
  endtask

  task automatic issue_m(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [4:0] rd, input logic ill);
    issue(tag, instr, pc, rsv(instr[19:15]), rsv(instr[24:20]), imm, rd, ill);
  endtask

  task automatic wb_cycle(input logic [4:0] addr, input logic [31:0] data);
    wb_we = 1'b1; wb_addr = addr; wb_data = data;
    tick();
    wb_we = 1'b0;
  endtask

  initial begin
    logic [31:0]  instr;
    logic [W-1:0] hold;
    if_valid = 0; if_instr = 0; if_pc = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
    ex_ready = 0; ex_flush = 0;
    #1 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ex_valid", {150'b0, ex_valid}, 151'd0);
    chk("rst_ex_fields", obs_vec, '0);
    chk("rst_if_ready", {150'b0, if_ready}, 151'd1);

    // reset while an instruction is held
    issue_m("hold_issue", enc_i(12'hFFF, 5'd0, 5'd5), 32'h50, 32'hFFFF_FFFF, 5'd5, 1'b0);
    #1 chk("hold_valid", {150'b0, ex_valid}, 151'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_ex_valid", {150'b0, ex_valid}, 151'd0);
    chk("midrst_ex_fields", obs_vec, '0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    drive(enc_i(12'h000, 5'd5, 5'd13), 32'h60);
    #1 chk("rst_sb_empty", {150'b0, if_ready}, 151'd1);
    if_valid = 1'b0;
    ex_ready = 1'b1;

    // immediates, back-to-back issue
    issue("addi_x0", enc_i(12'hFFF, 5'd0, 5'd5), 32'h100, 32'h0, rsv(5'd31), 32'hFFFF_FFFF,
          5'd5, 1'b0);
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h55;
    issue_m("beq_neg4", enc_b(13'h1FFC, 5'd2, 5'd1), 32'h104, 32'hFFFF_FFFC, 5'd0, 1'b0);
    wb_we = 1'b0;
    issue_m("lui", {20'h12345, 5'd3, 7'b0110111}, 32'h108, 32'h1234_5000, 5'd3, 1'b0);
    issue_m("sw_neg8", enc_s(12'hFF8, 5'd2, 5'd1), 32'h10C, 32'hFFFF_FFF8, 5'd0, 1'b0);
    issue_m("jal_2048", enc_j(21'h800, 5'd1), 32'h110, 32'h0000_0800, 5'd1, 1'b0);
    issue_m("auipc", {20'h80000, 5'd4, 7'b0010111}, 32'h114, 32'h8000_0000, 5'd4, 1'b0);
    wb_cycle(5'd3, 32'h33);
    wb_cycle(5'd1, 32'h11);
    wb_cycle(5'd4, 32'h44);

    // read-after-write interlock
    issue_m("raw_prod", enc_r(5'd2, 5'd1, 5'd6), 32'h200, 32'h0, 5'd6, 1'b0);
    instr = enc_r(5'd6, 5'd6, 5'd7);
    for (int k = 0; k < 2; k++) begin
      drive(instr, 32'h204);
      #1 chk("raw_stall", {150'b0, if_ready}, 151'd0);
      tick();
    end
    wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'h123;
`ifdef ID_STAGE_WB_BYPASS_EN
    issue("raw_bypass_issue", instr, 32'h204, 32'h123, 32'h123, 32'h0, 5'd7, 1'b0);
    wb_we = 1'b0;
`else
    drive(instr, 32'h204);
    #1 chk("raw_wb_stall", {150'b0, if_ready}, 151'd0);
    tick();
    wb_we = 1'b0;
    issue("raw_late_issue", instr, 32'h204, 32'h123, 32'h123, 32'h0, 5'd7, 1'b0);
`endif
    wb_cycle(5'd7, 32'h77);

    // backpressure
    instr = enc_i(12'd5, 5'd0, 5'd8);
    hold  = mk_exp(instr, 32'h300, 32'h0, rsv(instr[24:20]), 32'd5, 5'd8, 1'b0);
    issue_m("bp_first", instr, 32'h300, 32'd5, 5'd8, 1'b0);
    ex_ready = 1'b0;
    instr = enc_i(12'd7, 5'd0, 5'd10);
    for (int k = 0; k < 3; k++) begin
      drive(instr, 32'h304);
      #1;
      chk("bp_ready", {150'b0, if_ready}, 151'd0);
      chk("bp_valid", {150'b0, ex_valid}, 151'd1);
      chk("bp_stable", obs_vec, hold);
      tick();
    end
    ex_ready = 1'b1;
    issue_m("bp_release", instr, 32'h304, 32'd7, 5'd10, 1'b0);
    #1 chk("bp_next_pc", {119'b0, ex_pc}, {119'b0, 32'h304});
    wb_cycle(5'd8, 32'h88);
    wb_cycle(5'd10, 32'hAA);

    // flush
    ex_ready = 1'b0;
    issue_m("fl_x9", enc_i(12'd9, 5'd0, 5'd9), 32'h400, 32'd9, 5'd9, 1'b0);
    drive(enc_i(12'd1, 5'd0, 5'd14), 32'h4F0);
    ex_flush = 1'b1;
    #1 chk("fl_no_issue", {150'b0, if_ready}, 151'd0);
    void'(exp_q.pop_back());
    tick();
    ex_flush = 1'b0;
    if_valid = 1'b0;
    ex_ready = 1'b1;
    #1 chk("fl_valid", {150'b0, ex_valid}, 151'd0);
    issue_m("fl_dep_x9", enc_r(5'd9, 5'd9, 5'd11), 32'h404, 32'h0, 5'd11, 1'b0);
    #1 chk("fl_dep_pc", {119'b0, ex_pc}, {119'b0, 32'h404});

    // illegal opcode with rd field 5
    issue_m("illegal", 32'hABCD_E2FF, 32'h500, 32'h0, 5'd0, 1'b1);
    issue_m("ill_no_pend", enc_i(12'd1, 5'd5, 5'd12), 32'h504, 32'd1, 5'd12, 1'b0);
    wb_cycle(5'd11, 32'hBB);
    wb_cycle(5'd12, 32'hCC);

    for (int k = 0; k < 8 && exp_q.size() != 0; k++) tick();
    chk("drain_empty", W'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
